// File: rtl/ttc_stream_tx.sv
// rtl/ttc_stream_tx.sv - emulated TTC serial transmitter: command FIFO, sync insertion, UI stretch/shrink injection
module ttc_stream_tx #(
    parameter logic [15:0] SYNC_WORD     = 16'h817E,
    parameter int          SYNC_INTERVAL = 32,
    parameter int          FIFO_DEPTH    = 8,
    parameter int          UI_CYCLES     = 4
) (
    input  logic                          clk640,
    input  logic                          rst,
    input  logic                          wr_en,
    input  logic [15:0]                   wr_data,
    output logic                          fifo_full,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    input  logic                          stretch_req,
    input  logic                          shrink_req,
    output logic                          dataout,
    output logic                          frame_start,
    output logic                          frame_is_sync
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [4:0] UI_NOM   = 5'(UI_CYCLES);
    localparam logic [4:0] UI_LONG  = 5'(UI_CYCLES + 1);
    localparam logic [4:0] UI_SHORT = 5'(UI_CYCLES - 1);
    localparam logic [7:0] GAP_MAX  = 8'(SYNC_INTERVAL);
    localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);

    logic [15:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          full_q, full_d, overflow_q, overflow_d;
    logic [15:0]   shreg_q, shreg_d;
    logic [4:0]    ui_cnt_q, ui_cnt_d, ui_len_q, ui_len_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    sync_gap_q, sync_gap_d;
    logic          arm_q, arm_d, run_q, run_d;
    logic          pend_q, pend_d, pend_shrink_q, pend_shrink_d;
    logic          load_q, load_d, load_sync_q, load_sync_d;
    logic          dataout_q, dataout_d, frame_start_q, frame_start_d;
    logic          frame_is_sync_q, frame_is_sync_d;

    logic push, pop, load, shift, bit_end, send_sync, eff_pend, eff_shrink;

    always_comb begin
        wr_ptr_d        = wr_ptr_q;
        rd_ptr_d        = rd_ptr_q;
        level_d         = level_q;
        full_d          = full_q;
        overflow_d      = overflow_q;
        shreg_d         = shreg_q;
        ui_cnt_d        = ui_cnt_q;
        ui_len_d        = ui_len_q;
        bit_cnt_d       = bit_cnt_q;
        sync_gap_d      = sync_gap_q;
        arm_d           = 1'b1;
        run_d           = run_q;
        pend_d          = pend_q;
        pend_shrink_d   = pend_shrink_q;
        pop             = 1'b0;
        send_sync       = 1'b0;

        // full_q is the registered state, so a write in the pop cycle of a full FIFO is still dropped
        push       = wr_en && !full_q;
        overflow_d = overflow_q || (wr_en && full_q);

        bit_end = run_q && (ui_cnt_q == ui_len_q - 5'd1);
        load    = (arm_q && !run_q) || (bit_end && (bit_cnt_q == 4'd0));
        shift   = bit_end && (bit_cnt_q != 4'd0);

        if (load) begin
            run_d     = 1'b1;
            bit_cnt_d = 4'd15;
            if (sync_gap_q == GAP_MAX || level_q == '0) begin
                send_sync  = 1'b1;
                shreg_d    = SYNC_WORD;
                sync_gap_d = 8'd0;
            end else begin
                pop        = 1'b1;
                shreg_d    = mem_q[rd_ptr_q];
                sync_gap_d = sync_gap_q + 8'd1;
            end
        end else if (shift) begin
            shreg_d   = {shreg_q[14:0], 1'b0};
            bit_cnt_d = bit_cnt_q - 4'd1;
        end

        if (load || shift) begin
            ui_cnt_d = 5'd0;
        end else if (run_q) begin
            ui_cnt_d = ui_cnt_q + 5'd1;
        end

        // A fresh request in a bit's last cycle is folded in so it lands on the very next bit
        eff_pend   = pend_q || (stretch_req ^ shrink_req);
        eff_shrink = pend_q ? pend_shrink_q : shrink_req;
        if (load || shift) begin
            ui_len_d = eff_pend ? (eff_shrink ? UI_SHORT : UI_LONG) : UI_NOM;
            pend_d   = 1'b0;
        end else begin
            pend_d        = eff_pend;
            pend_shrink_d = eff_shrink;
        end

        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        level_d = level_q + LW'(push) - LW'(pop);
        full_d  = (level_d == LVL_FULL);

        load_d          = load;
        load_sync_d     = load && send_sync;
        dataout_d       = shreg_q[15];
        frame_start_d   = load_q;
        frame_is_sync_d = load_q && load_sync_q;
    end

    always_ff @(posedge clk640 or posedge rst) begin
        if (rst) begin
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            level_q         <= '0;
            full_q          <= 1'b0;
            overflow_q      <= 1'b0;
            shreg_q         <= 16'd0;
            ui_cnt_q        <= 5'd0;
            ui_len_q        <= 5'd0;
            bit_cnt_q       <= 4'd0;
            sync_gap_q      <= 8'd0;
            arm_q           <= 1'b0;
            run_q           <= 1'b0;
            pend_q          <= 1'b0;
            pend_shrink_q   <= 1'b0;
            load_q          <= 1'b0;
            load_sync_q     <= 1'b0;
            dataout_q       <= 1'b0;
            frame_start_q   <= 1'b0;
            frame_is_sync_q <= 1'b0;
        end else begin
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            level_q         <= level_d;
            full_q          <= full_d;
            overflow_q      <= overflow_d;
            shreg_q         <= shreg_d;
            ui_cnt_q        <= ui_cnt_d;
            ui_len_q        <= ui_len_d;
            bit_cnt_q       <= bit_cnt_d;
            sync_gap_q      <= sync_gap_d;
            arm_q           <= arm_d;
            run_q           <= run_d;
            pend_q          <= pend_d;
            pend_shrink_q   <= pend_shrink_d;
            load_q          <= load_d;
            load_sync_q     <= load_sync_d;
            dataout_q       <= dataout_d;
            frame_start_q   <= frame_start_d;
            frame_is_sync_q <= frame_is_sync_d;
        end
    end

    always_ff @(posedge clk640) begin
        if (push) mem_q[wr_ptr_q] <= wr_data;
    end

    assign fifo_full     = full_q;
    assign fifo_level    = level_q;
    assign overflow      = overflow_q;
    assign dataout       = dataout_q;
    assign frame_start   = frame_start_q;
    assign frame_is_sync = frame_is_sync_q;

endmodule

// File: doc/ttc_stream_tx.md
Name: ttc_stream_tx

Overview:
- Emulated TTC serial transmitter that generates the `datain` stream consumed by the TTC input decoder.
- Serializes 16-bit command words, MSB first, at 160 Mb/s (UI = 4 clk640 cycles) from a small input FIFO.
- When no command is queued it inserts SYNC_WORD, and it forces a sync at a fixed interval so the decoder's channel aligner stays locked.
- Provides UI stretch/shrink injection so the bench can exercise the decoder's oversample-phase tracking.

Parameters:
- SYNC_WORD, 16'h817E, idle/sync frame pattern.
- SYNC_INTERVAL, 32, maximum consecutive data frames before a sync frame is forced (range 2..255).
- FIFO_DEPTH, 8, command FIFO entries (power of 2, 2..64).
- UI_CYCLES, 4, clk640 cycles per nominal bit (range 3..15).

Ports:
- clk640  in  1  serializer clock, 640 MHz.
- rst  in  1  asynchronous, active-high reset.
- wr_en  in  1  push wr_data into the FIFO.
- wr_data  in  16  command word.
- fifo_full  out  1  FIFO holds FIFO_DEPTH words.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- overflow  out  1  sticky: a write was dropped.
- stretch_req  in  1  one-cycle pulse: next bit lasts UI_CYCLES+1 cycles.
- shrink_req  in  1  one-cycle pulse: next bit lasts UI_CYCLES-1 cycles.
- dataout  out  1  serial TTC stream, registered.
- frame_start  out  1  high for the first clk640 cycle of each frame's MSB.
- frame_is_sync  out  1  qualifies frame_start: the frame is SYNC_WORD.

Behaviour:
- Reset: asynchronous, active-high, clock clk640. All outputs 0; FIFO emptied; counters cleared; pending requests cleared. Reset asserted mid-frame aborts the frame immediately, with dataout=0 during reset.
- Counters: ui_cnt counts 0..ui_len-1. bit_cnt counts 15 down to 0. sync_gap counts data frames since the last sync.
- Frame load: occurs at cycle 0 after reset release and at the last cycle of bit 0 of each frame. The loaded frame starts driving on the next cycle. Frame selection:
  - if sync_gap == SYNC_INTERVAL, send SYNC_WORD and clear sync_gap;
  - else if the FIFO is not empty, pop its head, send it, and increment sync_gap;
  - else send SYNC_WORD and clear sync_gap.
- First frame after reset is always a sync. Its MSB appears on dataout 2 cycles after the first rising clk640 with rst low.
- Shifting: dataout = shreg[15]. The shift register shifts left when ui_cnt == ui_len-1.
- frame_start/frame_is_sync: registered, aligned with the first cycle dataout carries bit 15.
- FIFO: synchronous write; pop only at frame load.
  - A write while fifo_full (registered state) is dropped and sets overflow. Overflow clears only on rst.
  - Write and pop in the same cycle: both happen and level is unchanged. If full, the write is still dropped because full is evaluated before the pop.
  - No bypass: a word written in the load cycle is not sent in that frame.
- Injection:
  - A request pulse sets a single pending flag with its direction. Further requests while pending are ignored.
  - stretch_req and shrink_req asserted in the same cycle cancel each other; no pending flag is set.
  - The pending flag is applied to the next bit that begins: ui_len = UI_CYCLES±1 for exactly that one bit, then the flag clears.
  - A request arriving in the last cycle of a bit applies to the immediately following bit.
- Frame length: each frame is 16·UI_CYCLES cycles when no injection occurs. Data words are never corrupted by injection; only the bit timing changes.
- fifo_level and fifo_full are registered and update the cycle after the push/pop.

Test Plan:
- Idle after reset, FIFO empty → SYNC_WORD frames back to back; frame_start every 64 cycles with frame_is_sync=1; the first MSB (1) appears 2 cycles after rst release.
- Write 16'hA5C3 during frame 0 → frame 1 carries A5C3 MSB first, each bit held 4 cycles, frame_is_sync=0; frame 2 is a sync.
- Write 40 words back-to-back with flow control on fifo_full → after 32 data frames one sync is forced, then the remaining 8 data frames follow; no word is lost; overflow stays 0.
- Fill the FIFO to 8 and write a 9th → the 9th is dropped, overflow=1, fifo_level=8; the following frames carry the first 8 words in order.
- Pulse stretch_req mid-frame → exactly one bit lasts 5 cycles and that frame is 65 cycles. Repeat with shrink_req → one 3-cycle bit, frame is 63 cycles. Pulse both together → no change.
- Assert rst at bit 7 of a data frame → dataout=0 immediately; FIFO is empty after release; the next frame is a sync.
